register_pipe: RTL and testbench



---
 rtl/register_pipe_if.sv | 39 +++
 rtl/register_pipe.sv | 81 ++++++++
 tb/tb_register_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_pipe_if.sv
// register_pipe_if: handshake bundle for register_pipe.
// master drives the pipe (producer + consumer side), slave is the pipe.
interface register_pipe_if #(
  parameter int N     = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  D;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  Q;
  logic [CW-1:0] count;

  modport master (
    output flush,
    output in_valid,
    output D,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  Q,
    input  count
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  D,
    input  out_ready,
    output in_ready,
    output out_valid,
    output Q,
    output count
  );
endinterface

// File: rtl/register_pipe.sv
// register_pipe: elastic DEPTH-stage register with valid/ready,
// collapsing bubbles, synchronous flush and occupancy count.
module register_pipe #(
  parameter int           N           = 32,
  parameter int           DEPTH       = 2,
  parameter logic [N-1:0] reset_value = '0
) (
  input logic            clock,
  input logic            reset,
  register_pipe_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_valid;
  logic [N-1:0]     r_data [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_acc;
  logic [DEPTH-1:0] w_src_valid;
  logic [N-1:0]     w_src_data [DEPTH];
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;

  // adv[i] = out_ready OR any bubble downstream of stage i
  always_comb begin
    logic v_chain;
    v_chain = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_adv[i] = v_chain;
      v_chain  = v_chain | ~r_valid[i];
    end
  end

  assign w_acc = ~r_valid | w_adv;

  always_comb begin
    w_src_valid[0] = bus.in_valid;
    w_src_data[0]  = bus.D;
    for (int i = 1; i < DEPTH; i++) begin
      w_src_valid[i] = r_valid[i-1];
      w_src_data[i]  = r_data[i-1];
    end
  end

  assign w_in_ready = w_acc[0] & ~bus.flush;
  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = r_valid[DEPTH-1] & bus.out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_data[i] <= reset_value;
    end else if (bus.flush) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_acc[i]) begin
          r_valid[i] <= w_src_valid[i];
          // bubbles never overwrite data
          if (w_src_valid[i])
            r_data[i] <= w_src_data[i];
        end
      end
      if (w_in_fire & ~w_out_fire)
        r_count <= r_count + 1'b1;
      else if (~w_in_fire & w_out_fire)
        r_count <= r_count - 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid[DEPTH-1];
  assign bus.Q         = r_data[DEPTH-1];
  assign bus.count     = r_count;

endmodule

// File: tb/tb_register_pipe.sv
// tb_register_pipe: scenario tasks with a queue scoreboard,
// DEPTH=3/N=32 instance plus a DEPTH=1/N=8 instance.
module tb_register_pipe;
  logic clock;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] q0[$];
  logic [7:0]  q1[$];

  register_pipe_if #(.N(32), .DEPTH(3)) b0();
  register_pipe_if #(.N(8),  .DEPTH(1)) b1();

  register_pipe #(
    .N(32), .DEPTH(3), .reset_value(32'hDEAD_BEEF)
  ) u0 (
    .clock(clock),
    .reset(reset),
    .bus  (b0)
  );

  register_pipe #(
    .N(8), .DEPTH(1), .reset_value(8'h00)
  ) u1 (
    .clock(clock),
    .reset(reset),
    .bus  (b1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    b0.out_ready = 1'b0;
    b0.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b0.D = 32'h100 + k;
      tick();
    end
    b0.in_valid = 1'b0;
    @(negedge clock);
    total++;
    if (b0.count !== 2'd3) begin
      bad++;
      $display("FAIL pre_reset_count got=%0d want=3", b0.count);
    end
    total++;
    if (b0.Q !== 32'h100) begin
      bad++;
      $display("FAIL pre_reset_q got=%h want=00000100", b0.Q);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (b0.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got=%b want=0", b0.out_valid);
    end
    total++;
    if (b0.Q !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL reset_q got=%h want=deadbeef", b0.Q);
    end
    total++;
    if (b0.count !== 2'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", b0.count);
    end
    total++;
    if (b0.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=1", b0.in_ready);
    end
    tick();
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    logic [31:0] e;
    b0.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      b0.in_valid = (c < 5);
      b0.D        = 32'(c + 1);
      @(negedge clock);
      if (c < 5) begin
        total++;
        if (b0.in_ready !== 1'b1) begin
          bad++;
          $display("FAIL stream_in_ready c=%0d got=%b want=1",
                   c, b0.in_ready);
        end
      end
      total++;
      if (b0.out_valid !== (c >= 3 && c < 8)) begin
        bad++;
        $display("FAIL stream_valid c=%0d got=%b want=%b",
                 c, b0.out_valid, (c >= 3 && c < 8));
      end
      if (b0.out_valid && b0.out_ready) begin
        e = (q0.size() != 0) ? q0.pop_front() : 32'hx;
        total++;
        if (b0.Q !== e) begin
          bad++;
          $display("FAIL stream_q c=%0d got=%h want=%h", c, b0.Q, e);
        end
      end
      if (b0.in_valid && b0.in_ready) q0.push_back(b0.D);
      tick();
    end
    b0.in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    int idx;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      b0.out_ready = (c >= 5);
      b0.in_valid  = (idx < 4);
      b0.D         = 32'(10 + idx);
      @(negedge clock);
      if (c == 3 || c == 4) begin
        total++;
        if (b0.in_ready !== 1'b0) begin
          bad++;
          $display("FAIL bp_in_ready c=%0d got=%b want=0", c, b0.in_ready);
        end
        total++;
        if (b0.count !== 2'd3) begin
          bad++;
          $display("FAIL bp_count c=%0d got=%0d want=3", c, b0.count);
        end
      end
      if (c == 5) begin
        total++;
        if (b0.in_ready !== 1'b1) begin
          bad++;
          $display("FAIL bp_release got=%b want=1", b0.in_ready);
        end
      end
      if (b0.out_valid && b0.out_ready) begin
        e = (q0.size() != 0) ? q0.pop_front() : 32'hx;
        total++;
        if (b0.Q !== e) begin
          bad++;
          $display("FAIL bp_order c=%0d got=%h want=%h", c, b0.Q, e);
        end
      end
      if (b0.in_valid && b0.in_ready) begin
        q0.push_back(b0.D);
        idx++;
      end
      tick();
    end
    b0.in_valid = 1'b0;
    total++;
    if (q0.size() != 0 || idx != 4) begin
      bad++;
      $display("FAIL bp_drain left=%0d pushed=%0d want=0/4", q0.size(), idx);
    end
  endtask

  task automatic test_bubble();
    logic [31:0] e;
    for (int c = 0; c < 9; c++) begin
      b0.in_valid  = (c == 0 || c == 3);
      b0.D         = (c == 0) ? 32'hA : 32'hB;
      b0.out_ready = (c >= 5);
      @(negedge clock);
      if (c == 4 || c == 5) begin
        total++;
        if (b0.count !== 2'd2) begin
          bad++;
          $display("FAIL bub_count c=%0d got=%0d want=2", c, b0.count);
        end
      end
      if (c == 5 || c == 6) begin
        total++;
        if (b0.out_valid !== 1'b1 ||
            b0.Q !== ((c == 5) ? 32'hA : 32'hB)) begin
          bad++;
          $display("FAIL bub_q c=%0d got=%b/%h want=1/%h", c,
                   b0.out_valid, b0.Q, (c == 5) ? 32'hA : 32'hB);
        end
      end
      if (c == 7) begin
        total++;
        if (b0.out_valid !== 1'b0 || b0.count !== 2'd0) begin
          bad++;
          $display("FAIL bub_empty got=%b/%0d want=0/0",
                   b0.out_valid, b0.count);
        end
      end
      if (b0.out_valid && b0.out_ready) begin
        e = (q0.size() != 0) ? q0.pop_front() : 32'hx;
        total++;
        if (b0.Q !== e) begin
          bad++;
          $display("FAIL bub_order c=%0d got=%h want=%h", c, b0.Q, e);
        end
      end
      if (b0.in_valid && b0.in_ready) q0.push_back(b0.D);
      tick();
    end
    b0.in_valid = 1'b0;
  endtask

  task automatic test_flush();
    logic [31:0] e;
    logic [31:0] vals [3];
    vals[0] = 32'h5A5A_0003;
    vals[1] = 32'h5A5A_0002;
    vals[2] = 32'h5A5A_0001;
    for (int c = 0; c < 8; c++) begin
      b0.out_ready = (c == 3);
      b0.flush     = (c == 3);
      b0.in_valid  = (c < 4);
      b0.D         = (c < 3) ? vals[c] : 32'h0000_77EE;
      @(negedge clock);
      if (c == 3) begin
        total++;
        if (b0.in_ready !== 1'b0) begin
          bad++;
          $display("FAIL fl_in_ready got=%b want=0", b0.in_ready);
        end
        total++;
        if (b0.out_valid !== 1'b1 || b0.Q !== vals[0]) begin
          bad++;
          $display("FAIL fl_deliver got=%b/%h want=1/%h",
                   b0.out_valid, b0.Q, vals[0]);
        end
      end
      if (c == 4) begin
        total++;
        if (b0.count !== 2'd0) begin
          bad++;
          $display("FAIL fl_count got=%0d want=0", b0.count);
        end
        total++;
        if (b0.Q !== vals[0]) begin
          bad++;
          $display("FAIL fl_q_hold got=%h want=%h", b0.Q, vals[0]);
        end
      end
      if (c >= 4) begin
        total++;
        if (b0.out_valid !== 1'b0) begin
          bad++;
          $display("FAIL fl_no_w c=%0d got=%b want=0", c, b0.out_valid);
        end
      end
      if (b0.out_valid && b0.out_ready) begin
        e = (q0.size() != 0) ? q0.pop_front() : 32'hx;
        total++;
        if (b0.Q !== e) begin
          bad++;
          $display("FAIL fl_order c=%0d got=%h want=%h", c, b0.Q, e);
        end
      end
      if (b0.in_valid && b0.in_ready) q0.push_back(b0.D);
      if (b0.flush) q0.delete();
      tick();
    end
    b0.flush    = 1'b0;
    b0.in_valid = 1'b0;
  endtask

  task automatic test_depth1();
    logic [7:0] e;
    logic       m_valid;
    logic       m_ready;
    for (int c = 0; c < 1010; c++) begin
      b1.in_valid  = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      b1.out_ready = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
      b1.D         = 8'($urandom);
      @(negedge clock);
      m_valid = (q1.size() != 0);
      m_ready = !m_valid || b1.out_ready;
      total++;
      if (b1.out_valid !== m_valid) begin
        bad++;
        $display("FAIL d1_valid c=%0d got=%b want=%b", c, b1.out_valid, m_valid);
      end
      total++;
      if (b1.in_ready !== m_ready) begin
        bad++;
        $display("FAIL d1_in_ready c=%0d got=%b want=%b", c, b1.in_ready, m_ready);
      end
      total++;
      if (b1.count !== 1'(q1.size())) begin
        bad++;
        $display("FAIL d1_count c=%0d got=%0d want=%0d", c, b1.count, q1.size());
      end
      if (m_valid && b1.out_ready) begin
        e = q1.pop_front();
        total++;
        if (b1.Q !== e) begin
          bad++;
          $display("FAIL d1_q c=%0d got=%h want=%h", c, b1.Q, e);
        end
      end
      if (b1.in_valid && m_ready) q1.push_back(b1.D);
      tick();
    end
    total++;
    if (q1.size() != 0) begin
      bad++;
      $display("FAIL d1_drain left=%0d want=0", q1.size());
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    b0.flush = 1'b0; b0.in_valid = 1'b0; b0.D = '0; b0.out_ready = 1'b0;
    b1.flush = 1'b0; b1.in_valid = 1'b0; b1.D = '0; b1.out_ready = 1'b0;
    #7 reset = 1'b0;
    tick();
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_depth1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
